// File: rtl/multiplier_n_seq.sv
// multiplier_n_seq: iterative shift-and-add unsigned multiplier, N x N -> 2N.
// One partial-product addition per cycle through adder_n_prefix (Kogge-Stone).
// Issue side: ready/start handshake. Writeback side: valid/ack handshake.
// Optional build macro: MULT_EARLY_TERM_EN (finish as soon as no multiplier
// bits remain, with a final barrel-shift alignment of the product).

module adder_n_prefix #(
  parameter int unsigned N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         c_in,
  output logic [N-1:0] sum,
  output logic         c_out
);

  localparam int unsigned L = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0] w_h;
  logic [N-1:0] w_g [0:L];
  logic [N-1:0] w_p [0:L];

  // Parallel-prefix generate/propagate tree; c_in is folded into bit 0's generate
  always_comb begin
    w_h = a ^ b;
    for (int unsigned l = 0; l <= L; l++) begin
      w_g[l] = '0;
      w_p[l] = '0;
    end
    w_g[0]    = a & b;
    w_g[0][0] = (a[0] & b[0]) | (w_h[0] & c_in);
    w_p[0]    = w_h;
    for (int unsigned l = 1; l <= L; l++) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (i >= (32'd1 << (l - 1))) begin
          w_g[l][i] = w_g[l-1][i] | (w_p[l-1][i] & w_g[l-1][i - (32'd1 << (l - 1))]);
          w_p[l][i] = w_p[l-1][i] & w_p[l-1][i - (32'd1 << (l - 1))];
        end else begin
          w_g[l][i] = w_g[l-1][i];
          w_p[l][i] = w_p[l-1][i];
        end
      end
    end
  end

  // Sum bits from half-sums and prefix carries
  always_comb begin
    sum   = w_h ^ {w_g[L][N-2:0], c_in};
    c_out = w_g[L][N-1];
  end

endmodule

module multiplier_n_seq #(
  parameter int unsigned N = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           ready,
  output logic           busy,
  output logic           valid,
  input  logic           ack,
  output logic [2*N-1:0] product
);

  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_next;
  logic [CW-1:0]  r_cnt;
  logic [N-1:0]   r_mcand;
  logic [N-1:0]   r_mplier;
  logic [2*N-1:0] r_prod;
  logic [N-1:0]   w_sum;
  logic           w_cout;
  logic           w_last;
  logic           w_add;

`ifdef MULT_EARLY_TERM_EN
  localparam logic [CW:0] LP_N = (CW+1)'(N);
  logic           w_zero;
  logic [CW:0]    w_shamt;
`endif

  adder_n_prefix #(.N(N)) u_add (
    .a     (r_prod[2*N-1:N]),
    .b     (r_mcand),
    .c_in  (1'b0),
    .sum   (w_sum),
    .c_out (w_cout)
  );

  // Iteration control decodes; mplier[0] always mirrors prod[0] during RUN
  always_comb begin
    w_last = (r_cnt == CW'(N - 1));
    w_add  = r_mplier[0];
`ifdef MULT_EARLY_TERM_EN
    w_zero  = (r_mplier == '0);
    w_shamt = LP_N - {1'b0, r_cnt};
`endif
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (start) w_next = RUN;
      RUN: begin
`ifdef MULT_EARLY_TERM_EN
        if (w_zero || w_last) w_next = DONE;
`else
        if (w_last) w_next = DONE;
`endif
      end
      DONE: if (ack) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    ready   = (r_state == IDLE);
    busy    = (r_state == RUN);
    valid   = (r_state == DONE);
    product = r_prod;
  end

  // Datapath: operand capture, one shift-and-add step per RUN cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_prod   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_mcand  <= a;
            r_mplier <= b;
            r_prod   <= {{N{1'b0}}, b};
            r_cnt    <= '0;
          end
        end
        RUN: begin
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + 1'b1;
`ifdef MULT_EARLY_TERM_EN
          // No multiplier bits left: the accumulator only needs its remaining
          // N-cnt right shifts, done in one step
          if (w_zero) begin
            r_prod <= r_prod >> w_shamt;
          end else if (w_add) begin
            r_prod <= {w_cout, w_sum, r_prod[N-1:1]};
          end else begin
            r_prod <= {1'b0, r_prod[2*N-1:1]};
          end
`else
          if (w_add) begin
            r_prod <= {w_cout, w_sum, r_prod[N-1:1]};
          end else begin
            r_prod <= {1'b0, r_prod[2*N-1:1]};
          end
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multiplier_n_seq.sv
// tb_multiplier_n_seq: directed and random checks of multiplier_n_seq at N=32 and N=8.
// Honours MULT_EARLY_TERM_EN for expected latencies.

module tb_multiplier_n_seq;

  logic        clk;
  logic        rst_n;

  logic        s32, ack32, rdy32, bsy32, vld32;
  logic [31:0] a32, b32;
  logic [63:0] p32;

  logic        s8, ack8, rdy8, bsy8, vld8;
  logic [7:0]  a8, b8;
  logic [15:0] p8;

  int unsigned n_tests;
  int unsigned n_fail;

`ifdef MULT_EARLY_TERM_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  multiplier_n_seq #(.N(32)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .start(s32), .a(a32), .b(b32),
    .ready(rdy32), .busy(bsy32), .valid(vld32), .ack(ack32), .product(p32)
  );

  multiplier_n_seq #(.N(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(s8), .a(a8), .b(b8),
    .ready(rdy8), .busy(bsy8), .valid(vld8), .ack(ack8), .product(p8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit w8, input logic st, input logic ak,
                       input logic [31:0] av, input logic [31:0] bv);
    if (w8) begin
      s8 = st; ack8 = ak; a8 = av[7:0]; b8 = bv[7:0];
    end else begin
      s32 = st; ack32 = ak; a32 = av; b32 = bv;
    end
  endtask

  function automatic logic rdy(input bit w8);
    return w8 ? rdy8 : rdy32;
  endfunction
  function automatic logic bsy(input bit w8);
    return w8 ? bsy8 : bsy32;
  endfunction
  function automatic logic vld(input bit w8);
    return w8 ? vld8 : vld32;
  endfunction
  function automatic logic [63:0] prd(input bit w8);
    return w8 ? {48'b0, p8} : p32;
  endfunction

  function automatic int unsigned exp_lat(input bit w8, input logic [31:0] bv);
    int unsigned n;
    int unsigned early;
    n = w8 ? 8 : 32;
    early = 1;
    for (int unsigned i = 0; i < n; i++)
      if (bv[i]) early = i + 2;
    if (early > n) early = n;
    return EARLY ? early : n;
  endfunction

  // Counts negedges after the accept edge until valid, bounded
  task automatic wait_valid(input bit w8, output int unsigned lat);
    lat = 0;
    while (!vld(w8) && lat < 200) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_op(input bit w8, input logic [31:0] av, input logic [31:0] bv,
                        input logic [63:0] exp, input int unsigned ackdly, input string tag);
    int unsigned lat;
    @(negedge clk);
    chk({tag, "_ready"}, {63'b0, rdy(w8)}, 64'd1);
    drive(w8, 1'b1, 1'b0, av, bv);
    @(negedge clk);
    drive(w8, 1'b0, 1'b0, '0, '0);
    wait_valid(w8, lat);
    chk({tag, "_lat"}, 64'(lat), 64'(exp_lat(w8, bv)));
    chk({tag, "_prod"}, prd(w8), exp);
    repeat (ackdly) @(negedge clk);
    chk({tag, "_hold"}, {63'b0, vld(w8)}, 64'd1);
    drive(w8, 1'b0, 1'b1, '0, '0);
    @(negedge clk);
    drive(w8, 1'b0, 1'b0, '0, '0);
    chk({tag, "_rdy_after_ack"}, {63'b0, rdy(w8)}, 64'd1);
    chk({tag, "_prod_retained"}, prd(w8), exp);
  endtask

  initial begin
    int unsigned lat;
    logic [31:0] ra, rb;
    n_tests = 0;
    n_fail  = 0;
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0);

    // Reset state
    @(negedge clk);
    chk("rst_ready32", {63'b0, rdy32}, 64'd1);
    chk("rst_busy32",  {63'b0, bsy32}, 64'd0);
    chk("rst_valid32", {63'b0, vld32}, 64'd0);
    chk("rst_prod32",  p32, 64'd0);
    chk("rst_ready8",  {63'b0, rdy8}, 64'd1);
    chk("rst_prod8",   {48'b0, p8}, 64'd0);
    rst_n = 1'b1;

    // Reset in the middle of RUN discards the operation
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 32'd7, 32'd9);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    repeat (3) @(negedge clk);
    chk("midrun_busy", {63'b0, bsy32}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("midrun_rst_ready", {63'b0, rdy32}, 64'd1);
    chk("midrun_rst_valid", {63'b0, vld32}, 64'd0);
    chk("midrun_rst_busy",  {63'b0, bsy32}, 64'd0);
    chk("midrun_rst_prod",  p32, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(1'b0, 32'd7, 32'd9, 64'd63, 0, "after_rst");

    // Basic and extreme vectors
    run_op(1'b0, 32'd12345, 32'd6789, 64'd83810205, 1, "basic32");
    run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 2, "max32");
    run_op(1'b1, 32'hFF, 32'hFF, 64'hFE01, 0, "max8");
    run_op(1'b1, 32'h00, 32'hAB, 64'h0, 1, "zero_a8");
    run_op(1'b1, 32'h80, 32'h02, 64'h0100, 0, "pow2_8");

    // Vectors exercising early termination timing
    run_op(1'b0, 32'd5, 32'd0, 64'd0, 0, "b0_32");
    run_op(1'b0, 32'd3, 32'd5, 64'd15, 0, "a3b5_32");
    run_op(1'b0, 32'd2, 32'h8000_0000, 64'h1_0000_0000, 0, "bmsb_32");
    run_op(1'b0, 32'd1, 32'd1, 64'd1, 0, "b1_32");

    // Handshake: start while busy, ack held low, ack+start together
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 32'h12, 32'h34);
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    repeat (3) @(negedge clk);
    chk("hs_busy", {63'b0, bsy8}, 64'd1);
    drive(1'b1, 1'b1, 1'b0, 32'hFF, 32'hFF);
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    chk("hs_start_ignored_rdy", {63'b0, rdy8}, 64'd0);
    wait_valid(1'b1, lat);
    chk("hs_prod", {48'b0, p8}, 64'h03A8);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hs_hold_valid", {63'b0, vld8}, 64'd1);
      chk("hs_hold_prod", {48'b0, p8}, 64'h03A8);
    end
    drive(1'b1, 1'b1, 1'b1, 32'h55, 32'h55);
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    chk("hs_ackstart_ready", {63'b0, rdy8}, 64'd1);
    chk("hs_ackstart_valid", {63'b0, vld8}, 64'd0);
    chk("hs_ackstart_busy",  {63'b0, bsy8}, 64'd0);
    chk("hs_ackstart_prod",  {48'b0, p8}, 64'h03A8);
    @(negedge clk);
    chk("hs_no_new_op", {63'b0, bsy8}, 64'd0);

    // Random back-to-back operations with random ack delay
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom;
      rb = $urandom;
      run_op(1'b0, ra, rb, {32'b0, ra} * {32'b0, rb}, $urandom_range(5, 0), "rand32");
    end
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom & 32'hFF;
      rb = $urandom & 32'hFF;
      run_op(1'b1, ra, rb, {32'b0, ra} * {32'b0, rb}, $urandom_range(5, 0), "rand8");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
